bcd_scan_counter: RTL and testbench
===================================

# bcd_scan_counter

Multi-digit BCD up/down counter with a built-in tick prescaler and a time-multiplexed digit scanner. It is the stage directly upstream of the 7-segment decoder: each cycle it presents one 4-bit BCD digit on `digit_value`, which feeds the decoder's `value` input. It also drives the active-low digit-enable lines of a common-anode multi-digit display. It serves as the counting/stopwatch front end for the lab display boards.

## Interface
- `DIGITS`, default 4: number of BCD digits; must be ≥ 1.
- `PRESCALE`, default 50000: clock cycles per count step while `en`=1; must be ≥ 1.
- `SCAN_DIV`, default 1000: clock cycles each digit stays selected; must be ≥ 1.

- `clk`, input, 1: system clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset; asynchronous, active-low.
- `en`, input, 1: count enable; gates the prescaler.
- `up`, input, 1: direction; 1 = increment, 0 = decrement.
- `clear`, input, 1: synchronous clear of the count and the prescaler.
- `load`, input, 1: synchronous load of `load_val`.
- `load_val`, input, 4*DIGITS: packed BCD load value; digit 0 is in bits [3:0].
- `count`, output, 4*DIGITS: current packed BCD count; digit 0 is the least-significant digit.
- `digit_value`, output, 4: BCD digit currently scanned, to the decoder.
- `digit_sel`, output, DIGITS: active-low one-hot digit enable.
- `wrap`, output, 1: one-cycle pulse when the count wraps past all-9s or past all-0s.

## Operation
- Prescaler `pre` (width $clog2(PRESCALE), minimum 1):
  - `step` = `en` && (`pre` == PRESCALE-1).
  - On `step`, `pre` returns to 0. Otherwise, if `en`=1, `pre` increments. If `en`=0, `pre` holds.
  - With PRESCALE=1, `step` = `en`.
- Count update priority per cycle: `clear` > `load` > `step`.
  - `clear`: count ← 0 and pre ← 0.
  - `load`: count ← `load_val` and pre ← 0. Any loaded digit greater than 9 is stored as 0; valid digits are stored unchanged.
  - `step` with `up`=1: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit, rippling through all digits in the same cycle.
  - `step` with `up`=0: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
- Wrap:
  - Up step from all-9s gives all-0s. Down step from all-0s gives all-9s.
  - In either case `wrap` is registered high for exactly the next cycle.
  - `wrap` never asserts on `clear` or `load`.
- Scanner, free-running and independent of `en`, `clear` and `load`:
  - Counter `scan` runs 0..SCAN_DIV-1.
  - At its terminal value it wraps to 0 and digit index `idx` advances, going 0..DIGITS-1 and then back to 0.
- Output mapping:
  - `digit_sel` = ~(1 << `idx`).
  - `digit_value` = `count[4*idx +: 4]`, combinational from registered `idx` and `count`.
- Internal digit values are always in 0..9, so `digit_value` never exceeds 9.
- Reset state (asynchronous on `rst_n`=0, held while low):
  - `pre`=0, `scan`=0, `idx`=0, `count`=0, `wrap`=0.
  - Therefore `digit_sel` = all ones except bit 0 = 0, and `digit_value`=0.

## Timing
- With `en` held at 1 from reset release, the first count change appears after the PRESCALE-th rising edge; later changes follow every PRESCALE edges.
- Dropping `en` freezes `pre`; counting resumes from the same phase when `en` returns to 1.
- `count` and `digit_value` update on the same edge as the qualifying step, load or clear.
- `wrap` is high in the cycle after the wrapping edge.
- A step that coincides with `clear` or `load` is discarded.
- Each digit is selected for exactly SCAN_DIV cycles. A full refresh takes DIGITS*SCAN_DIV cycles.
- `digit_sel` and `digit_value` change on the same edge, so there is no mismatched select/value cycle.
- Asserting `rst_n` mid-count forces every output to its reset value immediately, without waiting for a clock edge.

## Test plan
All scenarios use DIGITS=4, PRESCALE=4, SCAN_DIV=2 unless stated.
1. Reset and idle: pulse `rst_n` low, then keep `en`=0 for 20 cycles -> `count`=0x0000, `wrap`=0, `digit_sel` cycles 1110, 1101, 1011, 0111 with 2 cycles each, `digit_value`=0 throughout.
2. Up count with ripple: `en`=1, `up`=1 for 40 edges from reset -> `count`=0x0010; an increment occurs on every 4th edge; the 9→0 carry into digit 1 occurs on edge 40.
3. Wrap both directions: load 0x9999 and do one up step -> `count`=0x0000 and `wrap` is high for one cycle. Then `up`=0 and one step -> `count`=0x9999 and `wrap` is high for one cycle.
4. Priority and invalid load: raise `load` with `load_val`=0x12F4 on the same edge as a step -> `count`=0x1204 and `pre`=0. Next, raise `clear` and `load` together -> `count`=0x0000.
5. Scan content: load 0x4321 with `en`=0 -> the (`digit_sel`, `digit_value`) sequence is (1110, 1), (1101, 2), (1011, 3), (0111, 4), each held 2 cycles, then repeats.
6. Asynchronous reset mid-operation: count to 0x0007 and pull `rst_n` low between clock edges -> all outputs take their reset values before the next edge and stay there while `rst_n`=0.

Source files
------------

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with tick prescaler and digit scanner.
// Ports: clk/rst_n, en/up/clear/load/load_val in; count, digit_value, digit_sel, wrap out.
module bcd_scan_counter #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic [3:0]            digit_value,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  wrap
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [PW-1:0]          r_pre;
  logic [SW-1:0]          r_scan;
  logic [IW-1:0]          r_idx;
  logic [4*DIGITS-1:0]    r_count;
  logic                   r_wrap;

  logic                   w_step;
  logic [4*DIGITS-1:0]    w_inc;
  logic [4*DIGITS-1:0]    w_dec;
  logic [4*DIGITS-1:0]    w_ld;
  logic                   w_cy;
  logic                   w_bw;
  logic [3:0]             w_dv;

  assign w_step = en && (r_pre == PRE_LAST);

  // Ripple carry/borrow across all digits in one cycle.
  // A carry surviving the last digit means all-9s (or all-0s).
  always_comb begin
    w_inc = r_count;
    w_dec = r_count;
    w_cy  = 1'b1;
    w_bw  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_cy) begin
        if (r_count[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          w_cy = 1'b0;
        end
      end
      if (w_bw) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          w_bw = 1'b0;
        end
      end
    end
  end

  // Non-BCD load digits collapse to 0 so the count stays valid.
  for (genvar g = 0; g < DIGITS; g++) begin : g_ld
    assign w_ld[4*g +: 4] =
      (load_val[4*g +: 4] > 4'd9) ? 4'd0 : load_val[4*g +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_pre   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      priority case (1'b1)
        clear: begin
          r_count <= '0;
          r_pre   <= '0;
        end
        load: begin
          r_count <= w_ld;
          r_pre   <= '0;
        end
        w_step: begin
          r_pre <= '0;
          if (up) begin
            r_count <= w_inc;
            r_wrap  <= w_cy;
          end else begin
            r_count <= w_dec;
            r_wrap  <= w_bw;
          end
        end
        en: begin
          r_pre <= r_pre + PW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Scanner is free-running; control inputs never touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan <= '0;
      r_idx  <= '0;
    end else begin
      if (r_scan == SCAN_LAST) begin
        r_scan <= '0;
        if (r_idx == IDX_LAST) begin
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end else begin
        r_scan <= r_scan + SW'(1);
      end
    end
  end

  always_comb begin
    w_dv = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_dv = r_count[4*i +: 4];
      end
    end
  end

  assign count       = r_count;
  assign wrap        = r_wrap;
  assign digit_value = w_dv;
  assign digit_sel   = ~(DIGITS'(1) << r_idx);

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter.
// Tables, hand sequences and random stimulus against a decimal model.
module tb_bcd_scan_counter;

  localparam int DIG  = 4;
  localparam int PRE  = 4;
  localparam int SCAN = 2;
  localparam int MODV = 10000;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        up;
  logic        clear;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic [3:0]  digit_value;
  logic [3:0]  digit_sel;
  logic        wrap;

  int n_chk;
  int n_err;

  int m_val;
  int m_pre;
  int m_t;
  bit m_wrap;

  typedef struct {
    logic        clr;
    logic        ld;
    logic [15:0] lv;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[7];

  bcd_scan_counter #(
    .DIGITS  (DIG),
    .PRESCALE(PRE),
    .SCAN_DIV(SCAN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .up         (up),
    .clear      (clear),
    .load       (load),
    .load_val   (load_val),
    .count      (count),
    .digit_value(digit_value),
    .digit_sel  (digit_sel),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < DIG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int ld_value(input logic [15:0] x);
    int r;
    int p;
    int d;
    r = 0;
    p = 1;
    for (int i = 0; i < DIG; i++) begin
      d = int'(x[4*i +: 4]);
      if (d <= 9) r += d * p;
      p *= 10;
    end
    return r;
  endfunction

  task automatic model_edge();
    m_wrap = 1'b0;
    if (clear) begin
      m_val = 0;
      m_pre = 0;
    end else if (load) begin
      m_val = ld_value(load_val);
      m_pre = 0;
    end else if (en) begin
      if (m_pre == PRE - 1) begin
        m_pre = 0;
        if (up) begin
          m_wrap = (m_val == MODV - 1);
          m_val = (m_val + 1) % MODV;
        end else begin
          m_wrap = (m_val == 0);
          m_val = (m_val + MODV - 1) % MODV;
        end
      end else begin
        m_pre++;
      end
    end
    m_t++;
  endtask

  task automatic model_check();
    int idx;
    int dv;
    logic [3:0] sel;
    idx = (m_t / SCAN) % DIG;
    dv = m_val;
    for (int i = 0; i < idx; i++) dv = dv / 10;
    dv = dv % 10;
    sel = ~(4'b0001 << idx);
    chk("m_count", 32'(count), 32'(to_bcd(m_val)));
    chk("m_scan", {24'd0, digit_sel, digit_value}, {24'd0, sel, 4'(dv)});
    chk("m_wrap", 32'(wrap), 32'(m_wrap));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_cnt"}, 32'(count), 32'h0);
    chk({nm, "_sel"}, 32'(digit_sel), 32'hE);
    chk({nm, "_dv"}, 32'(digit_value), 32'h0);
    chk({nm, "_wrap"}, 32'(wrap), 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset("rst_hold");
    #1 rst_n = 1'b1;
    m_val = 0;
    m_pre = 0;
    m_t = 0;
    m_wrap = 1'b0;
    chk_reset("rst_out");
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    en = 1'b0;
    up = 1'b1;
    clear = 1'b0;
    load = 1'b0;
    load_val = '0;

    tbl[0] = '{1'b0, 1'b1, 16'h4321, 16'h4321};
    tbl[1] = '{1'b0, 1'b1, 16'h12F4, 16'h1204};
    tbl[2] = '{1'b0, 1'b1, 16'hABCD, 16'h0000};
    tbl[3] = '{1'b0, 1'b1, 16'h9999, 16'h9999};
    tbl[4] = '{1'b1, 1'b1, 16'h5555, 16'h0000};
    tbl[5] = '{1'b0, 1'b1, 16'h0909, 16'h0909};
    tbl[6] = '{1'b1, 1'b0, 16'h7777, 16'h0000};

    // Reset and idle scan.
    do_reset();
    repeat (20) cycle();

    // Up count with ripple into digit 1.
    do_reset();
    en = 1'b1;
    up = 1'b1;
    repeat (3) cycle();
    chk("up_e3", 32'(count), 32'h0);
    cycle();
    chk("up_e4", 32'(count), 32'h1);
    repeat (35) cycle();
    chk("up_e39", 32'(count), 32'h9);
    cycle();
    chk("up_e40", 32'(count), 32'h10);

    // Wrap in both directions.
    en = 1'b0;
    load = 1'b1;
    load_val = 16'h9999;
    cycle();
    load = 1'b0;
    en = 1'b1;
    repeat (4) cycle();
    chk("wrap_up_cnt", 32'(count), 32'h0);
    chk("wrap_up_hi", 32'(wrap), 32'h1);
    en = 1'b0;
    cycle();
    chk("wrap_up_lo", 32'(wrap), 32'h0);
    up = 1'b0;
    en = 1'b1;
    repeat (4) cycle();
    chk("wrap_dn_cnt", 32'(count), 32'h9999);
    chk("wrap_dn_hi", 32'(wrap), 32'h1);
    en = 1'b0;
    cycle();
    chk("wrap_dn_lo", 32'(wrap), 32'h0);

    // Load beats a coinciding step and resets the phase.
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    up = 1'b1;
    en = 1'b1;
    repeat (3) cycle();
    load = 1'b1;
    load_val = 16'h12F4;
    cycle();
    chk("prio_ld", 32'(count), 32'h1204);
    chk("prio_ldw", 32'(wrap), 32'h0);
    load = 1'b0;
    repeat (3) cycle();
    chk("prio_pre3", 32'(count), 32'h1204);
    cycle();
    chk("prio_pre4", 32'(count), 32'h1205);
    clear = 1'b1;
    load = 1'b1;
    load_val = 16'h5555;
    cycle();
    chk("prio_clr", 32'(count), 32'h0);
    clear = 1'b0;
    load = 1'b0;

    // Table of single-cycle clear/load vectors.
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      clear = tbl[i].clr;
      load = tbl[i].ld;
      load_val = tbl[i].lv;
      cycle();
      chk($sformatf("tbl%0d", i), 32'(count), 32'(tbl[i].exp));
    end
    clear = 1'b0;
    load = 1'b0;

    // Scan content.
    load = 1'b1;
    load_val = 16'h4321;
    cycle();
    load = 1'b0;
    repeat (16) cycle();

    // Randomized mix.
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 3) != 0);
      up = $urandom_range(0, 1) != 0;
      clear = ($urandom_range(0, 39) == 0);
      load = ($urandom_range(0, 19) == 0);
      load_val = 16'($urandom);
      if ($urandom_range(0, 9) == 0) load_val = 16'h9999;
      if ($urandom_range(0, 9) == 0) load_val = 16'h0000;
      cycle();
    end
    clear = 1'b0;
    load = 1'b0;

    // Asynchronous reset mid-count.
    do_reset();
    en = 1'b1;
    up = 1'b1;
    repeat (28) cycle();
    chk("ar_pre", 32'(count), 32'h7);
    #2 rst_n = 1'b0;
    #1 chk_reset("ar_now");
    repeat (3) begin
      @(negedge clk);
      chk_reset("ar_hold");
    end
    #1 rst_n = 1'b1;
    m_val = 0;
    m_pre = 0;
    m_t = 0;
    m_wrap = 1'b0;
    repeat (8) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
